ascon_fsm: RTL and testbench

Ascon-128 authenticated-encryption engine for a fixed-size frame. It encrypts a 1472-bit (23 × 64-bit block) pre-padded plaintext, using a 128-bit key, a 128-bit nonce and one 64-bit pre-padded associated-data block. It produces the 1472-bit ciphertext and a 128-bit tag. It sits between the UART frame register (which supplies the payload) and the transmit path. The Ascon permutation is internal and computes one round per clock.

---
 rtl/ascon_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_ascon_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_fsm.sv
// ascon_fsm: Ascon-128 encryption of a fixed 23-block frame with one AD block.
// A single-round permutation core runs one round per clock. A two-process FSM
// sequences initialisation, AD absorption, plaintext absorption, finalisation
// and the tag.
module ascon_fsm (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [1471:0] plain_text_i,
  input  logic [127:0]  key_i,
  input  logic [127:0]  nonce_i,
  input  logic [63:0]   da_i,
  output logic [127:0]  tag_o,
  output logic [1471:0] cipher_o
);

  localparam logic [63:0] IV = 64'h80400C0600000000;

  typedef enum logic [3:0] {
    IDLE, INIT, ABS_AD, PERM_AD, ABS_PT, PERM_PT, ABS_LAST, FINAL, TAG, DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [4:0][63:0]  x_reg, x_next;      // x_reg[0] is x0
  logic [3:0]        round_reg, round_next;
  logic [4:0]        blk_reg, blk_next;
  logic [127:0]      tag_next;
  logic              ct_we, ct_clr;
  logic [10:0]       pt_base;
  logic [63:0]       pt_blk, abs_x0;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [4:0][63:0] round_fn(input logic [4:0][63:0] s,
                                                input logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [4:0][63:0] o;
    a0 = s[0];
    a1 = s[1];
    a2 = s[2] ^ {56'b0, 4'd15 - r, r};
    a3 = s[3];
    a4 = s[4];
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    o[0] = a0 ^ rotr(a0, 19) ^ rotr(a0, 28);
    o[1] = a1 ^ rotr(a1, 61) ^ rotr(a1, 39);
    o[2] = a2 ^ rotr(a2, 1)  ^ rotr(a2, 6);
    o[3] = a3 ^ rotr(a3, 10) ^ rotr(a3, 17);
    o[4] = a4 ^ rotr(a4, 7)  ^ rotr(a4, 41);
    return o;
  endfunction

  // Plaintext block selected by the block index; block 0 sits at the MSBs.
  assign pt_base = 11'd1471 - {blk_reg, 6'b0};
  assign pt_blk  = plain_text_i[pt_base -: 64];
  assign abs_x0  = x_reg[0] ^ pt_blk;

  // Next-state, datapath and output-enable decode.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    round_next = round_reg;
    blk_next   = blk_reg;
    tag_next   = tag_o;
    ct_we      = 1'b0;
    ct_clr     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          x_next[0]  = IV;
          x_next[1]  = key_i[127:64];
          x_next[2]  = key_i[63:0];
          x_next[3]  = nonce_i[127:64];
          x_next[4]  = nonce_i[63:0];
          tag_next   = '0;
          ct_clr     = 1'b1;
          round_next = 4'd0;
          blk_next   = 5'd0;
          state_next = INIT;
        end
      end
      INIT: begin
        x_next = round_fn(x_reg, round_reg);
        if (round_reg == 4'd11) begin
          round_next = 4'd6;
          state_next = ABS_AD;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      ABS_AD: begin
        x_next[0]  = x_reg[0] ^ da_i;
        x_next[3]  = x_reg[3] ^ key_i[127:64];
        x_next[4]  = x_reg[4] ^ key_i[63:0];
        state_next = PERM_AD;
      end
      PERM_AD: begin
        x_next = round_fn(x_reg, round_reg);
        if (round_reg == 4'd11) begin
          round_next = 4'd6;
          blk_next   = 5'd0;
          state_next = ABS_PT;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      ABS_PT: begin
        x_next[0] = abs_x0;
        ct_we     = 1'b1;
        // Domain separation is folded into the first plaintext absorb.
        if (blk_reg == 5'd0) begin
          x_next[4] = x_reg[4] ^ 64'd1;
        end
        state_next = PERM_PT;
      end
      PERM_PT: begin
        x_next = round_fn(x_reg, round_reg);
        if (round_reg == 4'd11) begin
          round_next = 4'd6;
          blk_next   = blk_reg + 5'd1;
          state_next = (blk_reg == 5'd21) ? ABS_LAST : ABS_PT;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      ABS_LAST: begin
        x_next[0]  = abs_x0;
        x_next[1]  = x_reg[1] ^ key_i[127:64];
        x_next[2]  = x_reg[2] ^ key_i[63:0];
        ct_we      = 1'b1;
        round_next = 4'd0;
        state_next = FINAL;
      end
      FINAL: begin
        x_next = round_fn(x_reg, round_reg);
        if (round_reg == 4'd11) begin
          state_next = TAG;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      TAG: begin
        tag_next   = {x_reg[3] ^ key_i[127:64], x_reg[4] ^ key_i[63:0]};
        state_next = DONE;
      end
      DONE: begin
        if (!start_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Permutation state, counters and tag register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      x_reg     <= '0;
      round_reg <= 4'd0;
      blk_reg   <= 5'd0;
      tag_o     <= '0;
    end else begin
      x_reg     <= x_next;
      round_reg <= round_next;
      blk_reg   <= blk_next;
      tag_o     <= tag_next;
    end
  end

  // One ciphertext register per block; each captures only its own absorb.
  for (genvar gi = 0; gi < 23; gi++) begin : g_ct
    logic [63:0] ct_q;

    // Block gi is cleared on start and written when its block is absorbed.
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        ct_q <= '0;
      end else if (ct_clr) begin
        ct_q <= '0;
      end else if (ct_we && (blk_reg == 5'(gi))) begin
        ct_q <= abs_x0;
      end
    end

    assign cipher_o[1471-64*gi -: 64] = ct_q;
  end

endmodule

// File: tb/tb_ascon_fsm.sv
// Bench for ascon_fsm: a table of vectors whose expected outputs come from a
// lookup-table Ascon model, plus reset, latency and back-to-back sequences.
module tb_ascon_fsm;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1471:0] pt;
  logic [127:0]  key;
  logic [127:0]  nonce;
  logic [63:0]   da;
  logic [127:0]  tag;
  logic [1471:0] ct;

  ascon_fsm dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .plain_text_i (pt),
    .key_i        (key),
    .nonce_i      (nonce),
    .da_i         (da),
    .tag_o        (tag),
    .cipher_o     (ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]  key;
    logic [127:0]  nonce;
    logic [63:0]   da;
    logic [1471:0] pt;
    logic [1471:0] ct;
    logic [127:0]  tag;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Ascon 5-bit S-box, column value with x0 as the MSB.
  byte unsigned sbox [32] = '{8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
                              8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
                              8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
                              8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};

  logic [63:0] ms [5];

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] blk(input logic [1471:0] w, input int i);
    return w[1471-64*i -: 64];
  endfunction

  // Permutation rounds first..11 applied column by column through the S-box table.
  function automatic void perm(input int first);
    logic [63:0] o [5];
    logic [4:0]  col;
    logic [4:0]  v;
    for (int r = first; r < 12; r++) begin
      ms[2] = ms[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]};
        v = 5'(sbox[col]);
        o[0][b] = v[4];
        o[1][b] = v[3];
        o[2][b] = v[2];
        o[3][b] = v[1];
        o[4][b] = v[0];
      end
      ms[0] = o[0] ^ rotr(o[0], 19) ^ rotr(o[0], 28);
      ms[1] = o[1] ^ rotr(o[1], 61) ^ rotr(o[1], 39);
      ms[2] = o[2] ^ rotr(o[2], 1)  ^ rotr(o[2], 6);
      ms[3] = o[3] ^ rotr(o[3], 10) ^ rotr(o[3], 17);
      ms[4] = o[4] ^ rotr(o[4], 7)  ^ rotr(o[4], 41);
    end
  endfunction

  // Whole-frame encryption; fills in the expected ciphertext and tag.
  function automatic void model(inout vec_t v);
    ms[0] = 64'h80400C0600000000;
    ms[1] = v.key[127:64];
    ms[2] = v.key[63:0];
    ms[3] = v.nonce[127:64];
    ms[4] = v.nonce[63:0];
    perm(0);
    ms[0] = ms[0] ^ v.da;
    ms[3] = ms[3] ^ v.key[127:64];
    ms[4] = ms[4] ^ v.key[63:0];
    perm(6);
    v.ct = '0;
    for (int i = 0; i < 22; i++) begin
      ms[0] = ms[0] ^ blk(v.pt, i);
      v.ct[1471-64*i -: 64] = ms[0];
      if (i == 0) ms[4] = ms[4] ^ 64'd1;
      perm(6);
    end
    ms[0] = ms[0] ^ blk(v.pt, 22);
    v.ct[63:0] = ms[0];
    ms[1] = ms[1] ^ v.key[127:64];
    ms[2] = ms[2] ^ v.key[63:0];
    perm(0);
    v.tag = {ms[3] ^ v.key[127:64], ms[4] ^ v.key[63:0]};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.key   = {$urandom, $urandom, $urandom, $urandom};
    v.nonce = {$urandom, $urandom, $urandom, $urandom};
    v.da    = {$urandom, $urandom};
    for (int k = 0; k < 46; k++) v.pt[32*k +: 32] = $urandom;
    model(v);
    return v;
  endfunction

  function automatic int nz_blocks();
    int n = 0;
    for (int i = 0; i < 23; i++) if (blk(ct, i) != 64'd0) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Start an encryption (caller is at a negedge) and follow it to edge 'last'.
  task automatic run_vec(input vec_t v, input int last, input string nm);
    int e;
    key   = v.key;
    nonce = v.nonce;
    da    = v.da;
    pt    = v.pt;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk($sformatf("%s ct_cleared", nm), 128'(nz_blocks()), 128'd0);
        chk($sformatf("%s tag_cleared", nm), tag, 128'd0);
      end
      for (int i = 0; i < 23; i++) begin
        e = (i < 22) ? 20 + 7 * i : 174;
        if (n == e - 1) chk($sformatf("%s ct%0d_pre", nm, i), 128'(blk(ct, i)), 128'd0);
        if (n == e)     chk($sformatf("%s ct%0d", nm, i), 128'(blk(ct, i)), 128'(blk(v.ct, i)));
      end
      if (n == 186) chk($sformatf("%s tag_pre", nm), tag, 128'd0);
      if (n == 187) chk($sformatf("%s tag", nm), tag, v.tag);
      if (n == 192) begin
        for (int i = 0; i < 23; i++)
          chk($sformatf("%s ct%0d_hold", nm, i), 128'(blk(ct, i)), 128'(blk(v.ct, i)));
        chk($sformatf("%s tag_hold", nm), tag, v.tag);
      end
    end
    $display("run %s edges %0d tag %h", nm, last, tag);
  endtask

  vec_t vecs [6];
  vec_t rv;

  initial begin
    // Table: known-answer pattern, all-zero, zero with a flipped tail bit,
    // random, and the same random frame with only the nonce changed.
    vecs[0].key   = 128'h000102030405060708090A0B0C0D0E0F;
    vecs[0].nonce = 128'h000102030405060708090A0B0C0D0E0F;
    vecs[0].da    = 64'h0001020304050607;
    for (int j = 0; j < 184; j++) vecs[0].pt[1471-8*j -: 8] = 8'(j);
    vecs[1].key = '0; vecs[1].nonce = '0; vecs[1].da = '0; vecs[1].pt = '0;
    vecs[2] = vecs[1];
    vecs[2].pt[0] = 1'b1;
    vecs[3] = rand_vec();
    vecs[4] = vecs[3];
    vecs[4].nonce = vecs[3].nonce ^ 128'h1;
    vecs[5] = rand_vec();
    for (int k = 0; k < 6; k++) model(vecs[k]);

    rst = 1'b1; start = 1'b0; key = '0; nonce = '0; da = '0; pt = '0;
    repeat (3) @(negedge clk);
    chk("reset tag", tag, 128'd0);
    chk("reset ct", 128'(nz_blocks()), 128'd0);

    // Reset held with start high: nothing moves.
    key = vecs[0].key; nonce = vecs[0].nonce; pt = vecs[0].pt; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d tag", k), tag, 128'd0);
      chk($sformatf("rst_hold%0d ct", k), 128'(nz_blocks()), 128'd0);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Table-driven back-to-back runs (start low for a single cycle between).
    for (int k = 0; k < 6; k++) run_vec(vecs[k], 192, $sformatf("vec%0d", k));

    // Abort at E100 with an asynchronous reset between clock edges.
    run_vec(vecs[3], 100, "abort");
    #2;
    rst = 1'b1;
    #1;
    chk("abort tag", tag, 128'd0);
    chk("abort ct", 128'(nz_blocks()), 128'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_abort idle ct", 128'(nz_blocks()), 128'd0);
    chk("post_abort idle tag", tag, 128'd0);
    run_vec(vecs[3], 192, "restart");

    // Extra random frames.
    for (int k = 0; k < 2; k++) begin
      rv = rand_vec();
      run_vec(rv, 192, $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
